// File: rtl/sc_shiftout_pkg.sv
// sc_shiftout_pkg
// Shared definitions for the serial output stage:
//   - state_t       : 2-bit FSM state encoding (IDLE, SETUP, CLKHI, LATCH)
//   - divcnt_width  : width of the serial-clock divider counter for a CLKDIV
package sc_shiftout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    CLKHI = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Divider counter width: $clog2(CLKDIV), never less than one bit.
  function automatic int divcnt_width(input int clkdiv);
    return (clkdiv > 1) ? $clog2(clkdiv) : 1;
  endfunction

endpackage

// File: rtl/sc_shiftout_if.sv
// sc_shiftout_if
// Bundles the start/data request side and the serial clock/data/latch/busy
// side of the serial output stage.
//   master : drives start_InLow and data_InBUS, observes the serial outputs
//   slave  : the shift-out stage itself
interface sc_shiftout_if #(
  parameter int DATAWIDTH_BUS = 8
);

  logic                     SC_SHIFTOUT_start_InLow;
  logic [DATAWIDTH_BUS-1:0] SC_SHIFTOUT_data_InBUS;
  logic                     SC_SHIFTOUT_sclk_Out;
  logic                     SC_SHIFTOUT_sdata_Out;
  logic                     SC_SHIFTOUT_latch_Out;
  logic                     SC_SHIFTOUT_busy_Out;

  modport master (
    output SC_SHIFTOUT_start_InLow,
    output SC_SHIFTOUT_data_InBUS,
    input  SC_SHIFTOUT_sclk_Out,
    input  SC_SHIFTOUT_sdata_Out,
    input  SC_SHIFTOUT_latch_Out,
    input  SC_SHIFTOUT_busy_Out
  );

  modport slave (
    input  SC_SHIFTOUT_start_InLow,
    input  SC_SHIFTOUT_data_InBUS,
    output SC_SHIFTOUT_sclk_Out,
    output SC_SHIFTOUT_sdata_Out,
    output SC_SHIFTOUT_latch_Out,
    output SC_SHIFTOUT_busy_Out
  );

endinterface

// File: rtl/sc_shiftout_tick.sv
// sc_shiftout_tick
// Serial-clock divider. Counts system clocks within one FSM state and flags
// the last cycle of that state's CLKDIV-cycle dwell.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   clr   : restart the count (asserted on every state entry)
//   tick  : high while the count equals CLKDIV-1
module sc_shiftout_tick
  import sc_shiftout_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int              DIVW = divcnt_width(CLKDIV);
  localparam logic [DIVW-1:0] LAST = DIVW'(CLKDIV - 1);

  logic [DIVW-1:0] divcnt_q;
  logic [DIVW-1:0] divcnt_d;

  // Next divider count: restart on clear, saturate at the last count.
  always_comb begin
    divcnt_d = divcnt_q;
    if (clr) begin
      divcnt_d = '0;
    end else if (divcnt_q != LAST) begin
      divcnt_d = divcnt_q + DIVW'(1);
    end else begin
      divcnt_d = divcnt_q;
    end
  end

  // Divider count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      divcnt_q <= '0;
    end else begin
      divcnt_q <= divcnt_d;
    end
  end

  assign tick = (divcnt_q == LAST);

endmodule

// File: rtl/sc_shiftout.sv
// sc_shiftout
// Captures a parallel word on a falling edge of an active-low start request
// and shifts it out MSB-first on a clock/data/latch triple for a
// 74HC595-style shift register, then pulses the latch strobe.
//   SC_SHIFTOUT_CLOCK_50    : system clock, rising edge
//   SC_SHIFTOUT_RESET_InLow : synchronous active-low reset
//   bus (slave)             : start_InLow, data_InBUS in; sclk, sdata,
//                             latch, busy out (all outputs registered)
module sc_shiftout
  import sc_shiftout_pkg::*;
#(
  parameter int DATAWIDTH_BUS = 8,
  parameter int CLKDIV        = 4
) (
  input  logic          SC_SHIFTOUT_CLOCK_50,
  input  logic          SC_SHIFTOUT_RESET_InLow,
  sc_shiftout_if.slave  bus
);

  localparam int             BCW      = $clog2(DATAWIDTH_BUS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATAWIDTH_BUS - 1);

  state_t                   state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]           bitcnt_q, bitcnt_d;
  logic                     hist_q, hist_d;
  logic                     sclk_q, sclk_d;
  logic                     sdata_q, sdata_d;
  logic                     latch_q, latch_d;
  logic                     busy_q, busy_d;
  logic                     trigger_s;
  logic                     tick_s;
  logic                     clr_s;

  // A falling start edge only counts once the busy flag has dropped, so the
  // controller always sees busy low for at least one cycle between words.
  assign trigger_s = (state_q == IDLE) && hist_q && !bus.SC_SHIFTOUT_start_InLow && !busy_q;

  // Divider restarts on every state change and is held clear while idle.
  assign clr_s = (state_d != state_q) || (state_q == IDLE);

  sc_shiftout_tick #(
    .CLKDIV (CLKDIV)
  ) u_tick (
    .clk   (SC_SHIFTOUT_CLOCK_50),
    .rst_n (SC_SHIFTOUT_RESET_InLow),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // FSM state register.
  always_ff @(posedge SC_SHIFTOUT_CLOCK_50) begin
    if (!SC_SHIFTOUT_RESET_InLow) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trigger_s) state_d = SETUP;
        else           state_d = IDLE;
      end
      SETUP: begin
        if (tick_s) state_d = CLKHI;
        else        state_d = SETUP;
      end
      CLKHI: begin
        if (tick_s) begin
          if (bitcnt_q == LAST_BIT) state_d = LATCH;
          else                      state_d = SETUP;
        end else begin
          state_d = CLKHI;
        end
      end
      LATCH: begin
        if (tick_s) state_d = IDLE;
        else        state_d = LATCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: start history, word capture, left shift and bit count.
  always_comb begin
    hist_d   = bus.SC_SHIFTOUT_start_InLow;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (trigger_s) begin
      shreg_d  = bus.SC_SHIFTOUT_data_InBUS;
      bitcnt_d = '0;
    end else if ((state_q == CLKHI) && tick_s) begin
      shreg_d = {shreg_q[DATAWIDTH_BUS-2:0], 1'b0};
      // The final bit leaves the counter at W-1 rather than wrapping.
      if (bitcnt_q != LAST_BIT) bitcnt_d = bitcnt_q + BCW'(1);
      else                      bitcnt_d = bitcnt_q;
    end else begin
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
    end
  end

  // FSM output decode; results are registered one cycle behind the state.
  always_comb begin
    sclk_d  = 1'b0;
    sdata_d = 1'b0;
    latch_d = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
      end
      SETUP: begin
        sdata_d = shreg_q[DATAWIDTH_BUS-1];
        busy_d  = 1'b1;
      end
      CLKHI: begin
        sclk_d  = 1'b1;
        sdata_d = shreg_q[DATAWIDTH_BUS-1];
        busy_d  = 1'b1;
      end
      LATCH: begin
        latch_d = 1'b1;
        busy_d  = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers with synchronous reset.
  always_ff @(posedge SC_SHIFTOUT_CLOCK_50) begin
    if (!SC_SHIFTOUT_RESET_InLow) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      hist_q   <= 1'b1;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      latch_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      hist_q   <= hist_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      latch_q  <= latch_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.SC_SHIFTOUT_sclk_Out  = sclk_q;
  assign bus.SC_SHIFTOUT_sdata_Out = sdata_q;
  assign bus.SC_SHIFTOUT_latch_Out = latch_q;
  assign bus.SC_SHIFTOUT_busy_Out  = busy_q;

endmodule

// File: tb/tb_sc_shiftout.sv
// tb_sc_shiftout
// Self-checking bench for sc_shiftout. Two instances: A (W=8, CLKDIV=4) and
// B (W=4, CLKDIV=1). Each transfer is recorded edge by edge and compared
// with a waveform predicted from the serial timing rules.
module tb_sc_shiftout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  sc_shiftout_if #(.DATAWIDTH_BUS(8)) ifa ();
  sc_shiftout_if #(.DATAWIDTH_BUS(4)) ifb ();

  sc_shiftout #(.DATAWIDTH_BUS(8), .CLKDIV(4)) dut_a (
    .SC_SHIFTOUT_CLOCK_50    (clk),
    .SC_SHIFTOUT_RESET_InLow (rst_a),
    .bus                     (ifa.slave)
  );

  sc_shiftout #(.DATAWIDTH_BUS(4), .CLKDIV(1)) dut_b (
    .SC_SHIFTOUT_CLOCK_50    (clk),
    .SC_SHIFTOUT_RESET_InLow (rst_b),
    .bus                     (ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  logic s_sclk  [0:255];
  logic s_sdata [0:255];
  logic s_latch [0:255];
  logic s_busy  [0:255];

  task automatic drive(input int sel, input logic st, input logic [7:0] d);
    if (sel == 0) begin
      ifa.SC_SHIFTOUT_start_InLow = st;
      ifa.SC_SHIFTOUT_data_InBUS  = d;
    end else begin
      ifb.SC_SHIFTOUT_start_InLow = st;
      ifb.SC_SHIFTOUT_data_InBUS  = d[3:0];
    end
  endtask

  task automatic set_rst(input int sel, input logic v);
    if (sel == 0) rst_a = v;
    else          rst_b = v;
  endtask

  task automatic sample(input int sel, input int e);
    if (sel == 0) begin
      s_sclk[e]  = ifa.SC_SHIFTOUT_sclk_Out;
      s_sdata[e] = ifa.SC_SHIFTOUT_sdata_Out;
      s_latch[e] = ifa.SC_SHIFTOUT_latch_Out;
      s_busy[e]  = ifa.SC_SHIFTOUT_busy_Out;
    end else begin
      s_sclk[e]  = ifb.SC_SHIFTOUT_sclk_Out;
      s_sdata[e] = ifb.SC_SHIFTOUT_sdata_Out;
      s_latch[e] = ifb.SC_SHIFTOUT_latch_Out;
      s_busy[e]  = ifb.SC_SHIFTOUT_busy_Out;
    end
  endtask

  task automatic idle(input int n);
    ifa.SC_SHIFTOUT_start_InLow = 1'b1;
    ifb.SC_SHIFTOUT_start_InLow = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start low so that edge 0 samples it, keeps it low through edge
  // hold-1, optionally re-pulses start with new data after edge mid, and
  // optionally resets so that edge rst_at samples reset. Records edges 0..n.
  task automatic run(input int sel, input logic [7:0] d, input int hold, input int mid,
                     input logic [7:0] mdata, input int rst_at, input int n);
    logic [7:0] cd;
    logic       st;
    cd = d;
    st = 1'b0;
    drive(sel, st, cd);
    for (int e = 0; e <= n; e++) begin
      @(posedge clk);
      #1;
      sample(sel, e);
      if (e + 1 >= hold) st = 1'b1;
      if (mid > 0 && e == mid) begin
        cd = mdata;
        st = 1'b0;
      end
      if (mid > 0 && e == mid + 1) st = 1'b1;
      if (rst_at > 0 && e == rst_at - 1) set_rst(sel, 1'b0);
      if (rst_at > 0 && e == rst_at) set_rst(sel, 1'b1);
      drive(sel, st, cd);
    end
  endtask

  // which: 0 busy, 1 latch, 2 sclk
  function automatic logic sig_at(input int which, input int e);
    case (which)
      0:       return s_busy[e];
      1:       return s_latch[e];
      default: return s_sclk[e];
    endcase
  endfunction

  function automatic int rises(input int which, input int upto);
    int n = 0;
    for (int e = 1; e <= upto; e++)
      if (sig_at(which, e) === 1'b1 && sig_at(which, e - 1) === 1'b0) n++;
    return n;
  endfunction

  function automatic int highs(input int which, input int upto);
    int n = 0;
    for (int e = 0; e <= upto; e++)
      if (sig_at(which, e) === 1'b1) n++;
    return n;
  endfunction

  // Serial bits as seen by a receiver sampling sdata on each sclk rise.
  task automatic get_bits(input int upto, output logic [7:0] v, output int cnt);
    v   = 8'h00;
    cnt = 0;
    for (int e = 1; e <= upto; e++) begin
      if (s_sclk[e] === 1'b1 && s_sclk[e-1] === 1'b0) begin
        v = {v[6:0], s_sdata[e]};
        cnt++;
      end
    end
  endtask

  // Reference waveform from the timing rules: bit k presented from edge
  // 1+2kC, sclk high for the second half of its 2C-cycle slot, latch for C
  // cycles after the last bit, busy from edge 1 through (2W+1)C.
  task automatic expect_wave(input string name, input logic [7:0] d, input int w,
                             input int c, input int upto);
    int    first_bad [4];
    logic  got_bad   [4];
    logic  exp_bad   [4];
    string nm        [4];
    logic  ev        [4];
    logic  gv        [4];
    nm = '{"sclk", "sdata", "latch", "busy"};
    for (int i = 0; i < 4; i++) begin
      first_bad[i] = -1;
      got_bad[i]   = 1'b0;
      exp_bad[i]   = 1'b0;
    end
    for (int e = 0; e <= upto; e++) begin
      int k, ph;
      ev[0] = 1'b0;
      ev[1] = 1'b0;
      if (e >= 1 && e <= 2 * w * c) begin
        k     = (e - 1) / (2 * c);
        ph    = (e - 1) % (2 * c);
        ev[1] = d[w-1-k];
        ev[0] = (ph >= c);
      end
      ev[2] = (e >= 1 + 2 * w * c) && (e <= (2 * w + 1) * c);
      ev[3] = (e >= 1) && (e <= (2 * w + 1) * c);
      gv[0] = s_sclk[e];
      gv[1] = s_sdata[e];
      gv[2] = s_latch[e];
      gv[3] = s_busy[e];
      for (int i = 0; i < 4; i++) begin
        if (gv[i] !== ev[i] && first_bad[i] < 0) begin
          first_bad[i] = e;
          got_bad[i]   = gv[i];
          exp_bad[i]   = ev[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (first_bad[i] >= 0) begin
        errors++;
        $display("FAIL %s.%s edge %0d got %b expected %b", name, nm[i], first_bad[i],
                 got_bad[i], exp_bad[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] oa, ob;
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b1, 8'($urandom));
    drive(1, 1'b1, 8'($urandom));
    repeat (3) @(posedge clk);
    #1;
    oa = {ifa.SC_SHIFTOUT_sclk_Out, ifa.SC_SHIFTOUT_sdata_Out, ifa.SC_SHIFTOUT_latch_Out, ifa.SC_SHIFTOUT_busy_Out};
    ob = {ifb.SC_SHIFTOUT_sclk_Out, ifb.SC_SHIFTOUT_sdata_Out, ifb.SC_SHIFTOUT_latch_Out, ifb.SC_SHIFTOUT_busy_Out};
    checks++;
    if (oa !== 4'b0000) begin errors++; $display("FAIL reset_a got %b expected 0000", oa); end
    checks++;
    if (ob !== 4'b0000) begin errors++; $display("FAIL reset_b got %b expected 0000", ob); end
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle(5);
    oa = {ifa.SC_SHIFTOUT_sclk_Out, ifa.SC_SHIFTOUT_sdata_Out, ifa.SC_SHIFTOUT_latch_Out, ifa.SC_SHIFTOUT_busy_Out};
    ob = {ifb.SC_SHIFTOUT_sclk_Out, ifb.SC_SHIFTOUT_sdata_Out, ifb.SC_SHIFTOUT_latch_Out, ifb.SC_SHIFTOUT_busy_Out};
    checks++;
    if (oa !== 4'b0000) begin errors++; $display("FAIL post_reset_a got %b expected 0000", oa); end
    checks++;
    if (ob !== 4'b0000) begin errors++; $display("FAIL post_reset_b got %b expected 0000", ob); end
  endtask

  task automatic test_basic();
    logic [7:0] bits;
    int         cnt, lfirst, llast, blast;
    run(0, 8'hA5, 1, 0, 8'h00, 0, 80);
    expect_wave("basic", 8'hA5, 8, 4, 80);
    get_bits(80, bits, cnt);
    checks++;
    if (cnt !== 8 || bits !== 8'hA5) begin
      errors++;
      $display("FAIL basic_bits got %0d bits %h expected 8 bits a5", cnt, bits);
    end
    lfirst = -1; llast = -1; blast = -1;
    for (int e = 0; e <= 80; e++) begin
      if (s_latch[e] === 1'b1 && lfirst < 0) lfirst = e;
      if (s_latch[e] === 1'b1) llast = e;
      if (s_busy[e] === 1'b1) blast = e;
    end
    checks++;
    if (lfirst != 65 || llast != 68) begin
      errors++;
      $display("FAIL basic_latch got edges %0d..%0d expected 65..68", lfirst, llast);
    end
    checks++;
    if (blast + 1 != 69) begin
      errors++;
      $display("FAIL basic_busy_fall got edge %0d expected 69", blast + 1);
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      int         hold;
      d    = 8'($urandom);
      hold = $urandom_range(1, 8);
      run(0, d, hold, 0, 8'h00, 0, 80);
      expect_wave("random", d, 8, 4, 80);
      idle($urandom_range(2, 6));
    end
  endtask

  task automatic test_hold();
    run(0, 8'h3C, 200, 0, 8'h00, 0, 200);
    expect_wave("hold", 8'h3C, 8, 4, 200);
    checks++;
    if (rises(1, 200) != 1) begin
      errors++;
      $display("FAIL hold_latch_pulses got %0d expected 1", rises(1, 200));
    end
    checks++;
    if (rises(0, 200) != 1) begin
      errors++;
      $display("FAIL hold_transfers got %0d expected 1", rises(0, 200));
    end
    idle(20);
    checks++;
    if (ifa.SC_SHIFTOUT_busy_Out !== 1'b0) begin
      errors++;
      $display("FAIL hold_release_busy got %b expected 0", ifa.SC_SHIFTOUT_busy_Out);
    end
  endtask

  task automatic test_back_to_back();
    run(0, 8'h0F, 1, 20, 8'hFF, 0, 100);
    expect_wave("busy_edge", 8'h0F, 8, 4, 100);
    checks++;
    if (rises(0, 100) != 1) begin
      errors++;
      $display("FAIL busy_edge_transfers got %0d expected 1", rises(0, 100));
    end
    checks++;
    if (rises(1, 100) != 1) begin
      errors++;
      $display("FAIL busy_edge_latch_pulses got %0d expected 1", rises(1, 100));
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [7:0] bits;
    int         cnt, nz;
    d = 8'($urandom);
    run(0, d, 1, 0, 8'h00, 30, 60);
    expect_wave("pre_reset", d, 8, 4, 29);
    checks++;
    if ({s_sclk[30], s_sdata[30], s_latch[30], s_busy[30]} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_edge30 got %b expected 0000",
               {s_sclk[30], s_sdata[30], s_latch[30], s_busy[30]});
    end
    nz = 0;
    for (int e = 30; e <= 60; e++)
      if ({s_sclk[e], s_sdata[e], s_latch[e], s_busy[e]} !== 4'b0000) nz++;
    checks++;
    if (nz != 0 || highs(1, 60) != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d active edges %0d latch edges expected 0 0",
               nz, highs(1, 60));
    end
    idle(2);
    run(0, 8'h81, 1, 0, 8'h00, 0, 80);
    expect_wave("after_reset", 8'h81, 8, 4, 80);
    get_bits(80, bits, cnt);
    checks++;
    if (cnt !== 8 || bits !== 8'h81) begin
      errors++;
      $display("FAIL after_reset_bits got %0d bits %h expected 8 bits 81", cnt, bits);
    end
    idle(2);
  endtask

  task automatic test_sweep();
    logic [7:0] bits;
    int         cnt;
    run(1, 8'h0C, 1, 0, 8'h00, 0, 20);
    expect_wave("sweep", 8'h0C, 4, 1, 20);
    get_bits(20, bits, cnt);
    checks++;
    if (cnt !== 4 || bits[3:0] !== 4'hC) begin
      errors++;
      $display("FAIL sweep_bits got %0d bits %h expected 4 bits c", cnt, bits[3:0]);
    end
    checks++;
    if (highs(0, 20) != 9) begin
      errors++;
      $display("FAIL sweep_busy_cycles got %0d expected 9", highs(0, 20));
    end
    idle(2);
  endtask

  initial begin
    ifa.SC_SHIFTOUT_start_InLow = 1'b1;
    ifa.SC_SHIFTOUT_data_InBUS  = 8'h00;
    ifb.SC_SHIFTOUT_start_InLow = 1'b1;
    ifb.SC_SHIFTOUT_data_InBUS  = 4'h0;
    test_reset();
    test_basic();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
